// File: rtl/dds_sample_packetizer.sv
// Buffers the free-running DDS sample stream in a small FIFO and packs two samples per
// flit into fixed-length NoC packets: one header flit followed by PKT_SAMPLES/2 payload flits.
module dds_sample_packetizer #(
    parameter int SAMPLE_W    = 14,
    parameter int FLIT_W      = 32,
    parameter int PKT_SAMPLES = 8,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [3:0]          src_id,
    input  logic [3:0]          dest_id,
    input  logic                s_valid,
    input  logic [SAMPLE_W-1:0] s_data,
    output logic                flit_valid,
    output logic [FLIT_W-1:0]   flit_data,
    output logic                flit_last,
    input  logic                flit_ready,
    output logic [15:0]         overflow_cnt,
    output logic [15:0]         pkt_cnt
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam int BEATS = PKT_SAMPLES / 2;
    localparam int BW    = $clog2(BEATS + 1);

    typedef enum logic [1:0] {IDLE, HEAD, PAYLOAD} state_t;

    state_t              state;
    logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [CW-1:0]       count;
    logic [BW-1:0]       beat;
    logic [7:0]          seq;

    logic                handshake;
    logic                pop;
    logic                push;
    logic                drop;
    logic                pkt_done;
    logic                start_pkt;
    logic [CW-1:0]       count_after_pop;
    logic [7:0]          hdr_seq;
    logic [31:0]         header;
    logic [31:0]         first_pair;
    logic [31:0]         next_pair;

    function automatic logic [31:0] pack_pair(input logic [SAMPLE_W-1:0] older,
                                              input logic [SAMPLE_W-1:0] newer);
        logic [15:0] lo;
        logic [15:0] hi;
        lo = '0;
        hi = '0;
        lo[SAMPLE_W-1:0] = older;
        hi[SAMPLE_W-1:0] = newer;
        return {hi, lo};
    endfunction

    // Samples stay in the FIFO while shown on the flit bus; they are popped on the payload handshake.
    always_comb begin
        handshake       = flit_valid & flit_ready;
        pop             = handshake && (state == PAYLOAD);
        push            = s_valid && enable && ((count < CW'(FIFO_DEPTH)) || pop);
        drop            = s_valid && enable && !push;
        pkt_done        = pop && (beat == BW'(BEATS - 1));
        count_after_pop = pop ? count - CW'(2) : count;
        start_pkt       = enable && (count_after_pop >= CW'(PKT_SAMPLES))
                          && ((state == IDLE) || pkt_done);
        hdr_seq         = pkt_done ? seq + 8'd1 : seq;
        header          = {dest_id, src_id, hdr_seq, 8'(BEATS), 8'hA5};
        first_pair      = pack_pair(mem[rd_ptr], mem[rd_ptr + AW'(1)]);
        next_pair       = pack_pair(mem[rd_ptr + AW'(2)], mem[rd_ptr + AW'(3)]);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            flit_valid   <= 1'b0;
            flit_data    <= '0;
            flit_last    <= 1'b0;
            overflow_cnt <= '0;
            pkt_cnt      <= '0;
            seq          <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            beat         <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(2);
            end
            count <= count + (push ? CW'(1) : CW'(0)) - (pop ? CW'(2) : CW'(0));
            if (drop && (overflow_cnt != 16'hFFFF)) begin
                overflow_cnt <= overflow_cnt + 16'd1;
            end

            case (state)
                IDLE: begin
                    if (start_pkt) begin
                        state      <= HEAD;
                        flit_valid <= 1'b1;
                        flit_data  <= header;
                        flit_last  <= 1'b0;
                    end
                end
                HEAD: begin
                    if (handshake) begin
                        state     <= PAYLOAD;
                        flit_data <= first_pair;
                        flit_last <= (BEATS == 1);
                        beat      <= '0;
                    end
                end
                PAYLOAD: begin
                    if (handshake) begin
                        if (pkt_done) begin
                            pkt_cnt <= pkt_cnt + 16'd1;
                            seq     <= seq + 8'd1;
                            if (start_pkt) begin
                                state     <= HEAD;
                                flit_data <= header;
                                flit_last <= 1'b0;
                            end else begin
                                state      <= IDLE;
                                flit_valid <= 1'b0;
                                flit_data  <= '0;
                                flit_last  <= 1'b0;
                            end
                        end else begin
                            beat      <= beat + BW'(1);
                            flit_data <= next_pair;
                            flit_last <= ((beat + BW'(1)) == BW'(BEATS - 1));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dds_sample_packetizer.sv
// Self-checking bench for dds_sample_packetizer: a ramp vector table, directed corner
// sequences, and a randomized run, all compared against a queue-based packet model.
module tb_dds_sample_packetizer;

    localparam int SAMPLE_W    = 14;
    localparam int PKT_SAMPLES = 8;
    localparam int FIFO_DEPTH  = 16;
    localparam int BEATS       = PKT_SAMPLES / 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                enable = 1'b0;
    logic [3:0]          src_id = 4'd5;
    logic [3:0]          dest_id = 4'd3;
    logic                s_valid = 1'b0;
    logic [SAMPLE_W-1:0] s_data = '0;
    logic                flit_valid;
    logic [31:0]         flit_data;
    logic                flit_last;
    logic                flit_ready = 1'b0;
    logic [15:0]         overflow_cnt;
    logic [15:0]         pkt_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dds_sample_packetizer #(
        .SAMPLE_W   (SAMPLE_W),
        .FLIT_W     (32),
        .PKT_SAMPLES(PKT_SAMPLES),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .src_id      (src_id),
        .dest_id     (dest_id),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .flit_valid  (flit_valid),
        .flit_data   (flit_data),
        .flit_last   (flit_last),
        .flit_ready  (flit_ready),
        .overflow_cnt(overflow_cnt),
        .pkt_cnt     (pkt_cnt)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; holds the inputs across the next posedge and returns at the following negedge.
    task automatic applyStimulus(input logic rst, input logic sv, input logic [SAMPLE_W-1:0] sd,
                                 input logic en, input logic rdy);
        rst_n      = rst;
        s_valid    = sv;
        s_data     = sd;
        enable     = en;
        flit_ready = rdy;
        @(negedge clk);
    endtask

    // Reference model: FIFO as a queue, packet progress as a count of flits still to send.
    logic [SAMPLE_W-1:0] mq[$];
    int                  m_left = 0;
    logic [7:0]          m_seq = '0;
    logic [15:0]         m_ovf = '0;
    logic [15:0]         m_pkts = '0;
    logic [31:0]         m_hdr = '0;
    bit                  m_live = 1'b0;

    always @(posedge clk) begin
        bit hs;
        bit popping;
        bit do_push;
        if (!rst_n) begin
            mq.delete();
            m_left = 0;
            m_seq  = '0;
            m_ovf  = '0;
            m_pkts = '0;
            m_hdr  = '0;
            m_live = 1'b1;
        end else begin
            hs      = (m_left > 0) && flit_ready;
            popping = hs && (m_left <= BEATS);
            do_push = 1'b0;
            if (s_valid && enable) begin
                if ((mq.size() < FIFO_DEPTH) || popping) do_push = 1'b1;
                else if (m_ovf != 16'hFFFF) m_ovf = m_ovf + 16'd1;
            end
            if (hs) begin
                if (popping) begin
                    void'(mq.pop_front());
                    void'(mq.pop_front());
                end
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_pkts = m_pkts + 16'd1;
                    m_seq  = m_seq + 8'd1;
                end
            end
            if ((m_left == 0) && enable && (mq.size() >= PKT_SAMPLES)) begin
                m_left = BEATS + 1;
                m_hdr  = {dest_id, src_id, m_seq, 8'(BEATS), 8'hA5};
            end
            if (do_push) mq.push_back(s_data);
        end
    end

    always @(negedge clk) begin
        logic [31:0] exp_data;
        if (m_live) begin
            checkOutput("model_valid", 32'(flit_valid), 32'(m_left > 0));
            checkOutput("model_last", 32'(flit_last), 32'(m_left == 1));
            checkOutput("model_overflow_cnt", 32'(overflow_cnt), 32'(m_ovf));
            checkOutput("model_pkt_cnt", 32'(pkt_cnt), 32'(m_pkts));
            if (m_left > 0) begin
                if (m_left == BEATS + 1) exp_data = m_hdr;
                else exp_data = {16'(mq[1]), 16'(mq[0])};
                checkOutput("model_flit_data", flit_data, exp_data);
            end
        end
    end

    typedef struct {
        logic                sv;
        logic [SAMPLE_W-1:0] sd;
        logic                ex_valid;
        logic [31:0]         ex_data;
        logic                ex_last;
        logic [15:0]         ex_pkt;
    } vec_t;

    vec_t vecs[14];

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Ramp 1..8, dest 3 / src 5, router always ready: header then four packed pairs.
        for (int i = 0; i < 14; i++) begin
            vecs[i].sv       = (i < 8);
            vecs[i].sd       = (i < 8) ? SAMPLE_W'(i + 1) : '0;
            vecs[i].ex_valid = (i >= 8) && (i <= 12);
            vecs[i].ex_data  = '0;
            vecs[i].ex_last  = (i == 12);
            vecs[i].ex_pkt   = (i == 13) ? 16'd1 : 16'd0;
        end
        vecs[8].ex_data  = 32'h3500_04A5;
        vecs[9].ex_data  = 32'h0002_0001;
        vecs[10].ex_data = 32'h0004_0003;
        vecs[11].ex_data = 32'h0006_0005;
        vecs[12].ex_data = 32'h0008_0007;

        @(negedge clk);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
        checkOutput("reset_valid", 32'(flit_valid), 32'd0);
        checkOutput("reset_data", flit_data, 32'd0);
        checkOutput("reset_last", 32'(flit_last), 32'd0);
        checkOutput("reset_overflow_cnt", 32'(overflow_cnt), 32'd0);
        checkOutput("reset_pkt_cnt", 32'(pkt_cnt), 32'd0);

        $display("[TB] ramp vector table");
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b1, vecs[i].sv, vecs[i].sd, 1'b1, 1'b1);
            checkOutput($sformatf("ramp_valid[%0d]", i), 32'(flit_valid), 32'(vecs[i].ex_valid));
            checkOutput($sformatf("ramp_last[%0d]", i), 32'(flit_last), 32'(vecs[i].ex_last));
            checkOutput($sformatf("ramp_pkt_cnt[%0d]", i), 32'(pkt_cnt), 32'(vecs[i].ex_pkt));
            if (vecs[i].ex_valid)
                checkOutput($sformatf("ramp_data[%0d]", i), flit_data, vecs[i].ex_data);
        end

        $display("[TB] continuous stream, back-to-back packets");
        for (int i = 0; i < 80; i++) applyStimulus(1'b1, 1'b1, SAMPLE_W'($urandom), 1'b1, 1'b1);
        checkOutput("stream_overflow_cnt", 32'(overflow_cnt), 32'd0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b1);

        $display("[TB] router stall with streaming input");
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b1, SAMPLE_W'(i + 1), 1'b1, 1'b0);
        checkOutput("stall_overflow_cnt", 32'(overflow_cnt), 32'd24);
        checkOutput("stall_valid", 32'(flit_valid), 32'd1);
        checkOutput("stall_header", flit_data, 32'h3500_04A5);
        for (int i = 0; i < 30; i++) applyStimulus(1'b1, 1'b1, SAMPLE_W'(100 + i), 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b1);

        $display("[TB] enable dropped after header handshake");
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, SAMPLE_W'(200 + i), 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b1, SAMPLE_W'(300 + i), 1'b0, 1'b1);
        checkOutput("disable_valid", 32'(flit_valid), 32'd0);
        checkOutput("disable_overflow_cnt", 32'(overflow_cnt), 32'd0);
        checkOutput("disable_pkt_cnt", 32'(pkt_cnt), 32'd1);

        $display("[TB] reset in the middle of a payload");
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, SAMPLE_W'(400 + i), 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, SAMPLE_W'(999), 1'b1, 1'b1);
        checkOutput("midreset_valid", 32'(flit_valid), 32'd0);
        checkOutput("midreset_overflow_cnt", 32'(overflow_cnt), 32'd0);
        checkOutput("midreset_pkt_cnt", 32'(pkt_cnt), 32'd0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, SAMPLE_W'(500 + i), 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b1);
        checkOutput("midreset_header", flit_data, 32'h3500_04A5);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b1);

        $display("[TB] 257 packets for sequence wrap");
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 257 * PKT_SAMPLES; i++)
            applyStimulus(1'b1, 1'b1, SAMPLE_W'($urandom), 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b1);
        checkOutput("wrap_pkt_cnt", 32'(pkt_cnt), 32'd257);
        checkOutput("wrap_overflow_cnt", 32'(overflow_cnt), 32'd0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                src_id  = 4'($urandom);
                dest_id = 4'($urandom);
            end
            applyStimulus(($urandom_range(0, 599) != 0), ($urandom_range(0, 3) != 0),
                          SAMPLE_W'($urandom), ($urandom_range(0, 15) != 0),
                          ($urandom_range(0, 2) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dds_sample_packetizer.md
Name: dds_sample_packetizer

Overview:
Downstream consumer of the DDS sine-lookup stage. Takes the free-running 14-bit sine sample stream, buffers it in a small sample FIFO, and packs the samples two per flit into fixed-length NoC packets with a header flit. Output is a valid/ready flit stream toward the NoC router injection port. The DDS stage has no backpressure, so input overruns are dropped and counted.

Parameters:
SAMPLE_W, 14, sample width; must be ≤ 16.
FLIT_W, 32, flit width; fixed at 32.
PKT_SAMPLES, 8, samples per packet; even, 2..FIFO_DEPTH.
FIFO_DEPTH, 16, sample FIFO depth; power of 2.

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
enable  in  1  1 = accept samples and start packets
src_id  in  4  source node id, written into the header
dest_id  in  4  destination node id, written into the header
s_valid  in  1  sample strobe from the DDS stage
s_data  in  SAMPLE_W  sine sample
flit_valid  out  1  flit available
flit_data  out  32  flit payload
flit_last  out  1  last flit of the packet
flit_ready  in  1  router accepts the flit
overflow_cnt  out  16  count of dropped samples, saturating
pkt_cnt  out  16  count of completed packets, wrapping

Behaviour:
- Reset, when rst_n = 0 at a posedge: flit_valid = 0, flit_data = 0, flit_last = 0, overflow_cnt = 0, pkt_cnt = 0, seq = 0, FIFO empty, FSM = IDLE. Reset mid-packet abandons the packet; no flits follow.
- Input, each cycle with s_valid = 1:
  - enable = 0: sample discarded; overflow_cnt does not change.
  - enable = 1 and the pre-edge count < FIFO_DEPTH, or a pop happens in the same cycle: sample pushed.
  - Otherwise: sample dropped, and overflow_cnt increments, saturating at 0xFFFF.
- FSM states IDLE, HEAD, PAYLOAD:
  - IDLE -> HEAD: when enable = 1 and count ≥ PKT_SAMPLES. dest_id and src_id are latched at this edge, and the header flit is registered. flit_valid rises on that same edge, i.e. 1 cycle after the edge that writes the PKT_SAMPLES-th sample.
  - HEAD -> PAYLOAD: on handshake (flit_valid & flit_ready).
  - In PAYLOAD, each handshake pops 2 samples and loads the next flit. After PKT_SAMPLES/2 payload flits, go to IDLE, increment pkt_cnt and seq, and drop flit_valid unless IDLE -> HEAD fires on the same edge (back-to-back packets allowed, no bubble required).
- Header flit format:
  - [31:28] = dest_id
  - [27:24] = src_id
  - [23:16] = seq, 8-bit, wraps at 255 -> 0
  - [15:8] = PKT_SAMPLES/2
  - [7:0] = 8'hA5
- Payload flit: [15:0] = older sample, zero-extended; [31:16] = newer sample, zero-extended.
- flit_last = 1 only on the final payload flit.
- While flit_valid = 1 and flit_ready = 0, flit_data, flit_last and flit_valid hold stable.
- enable falling mid-packet: the current packet completes normally; no new packet starts; samples already in the FIFO are kept.
- No packet is ever started without PKT_SAMPLES samples already in the FIFO, so payload flits never underrun.
- Sample order is preserved end-to-end; no sample is duplicated.

Test Plan:
- Ramp samples 1..8 with enable = 1, dest_id = 3, src_id = 5, flit_ready = 1 -> 5 flits:
  - header 32'h3500_04A5
  - 32'h0002_0001, 32'h0004_0003, 32'h0006_0005, 32'h0008_0007
  - flit_last only on the 5th flit; pkt_cnt = 1
- Continuous s_valid every cycle with flit_ready = 1 -> packets back-to-back; header seq = 0,1,2,…; overflow_cnt stays 0.
- flit_ready = 0 for 40 cycles while s_valid streams -> header held stable; FIFO fills to 16 (header not yet popped); overflow_cnt = number of extra strobes. After release, payload order stays contiguous up to the first drop.
- enable dropped after the header handshake -> remaining 4 payload flits still delivered; then flit_valid = 0 while 8 further samples arrive (discarded, overflow_cnt unchanged).
- rst_n = 0 for 1 cycle mid-payload -> next cycle flit_valid = 0 and all counters 0; the next packet's header has seq = 0 and its payload holds only samples arriving after reset.
- 257 packets -> seq field wraps to 0 on packet 257; pkt_cnt = 257.
